// File: rtl/neopixel_ctrl_arbiter.sv
// Two-requester write arbiter in front of a NeoPixel controller.
// Each requester owns a single-entry buffer; buffered writes are issued
// downstream one at a time with round-robin selection on ties. Writes
// aimed past the last pixel are rejected and counted in drop_count.
module neopixel_ctrl_arbiter #(
    parameter int C_PIXELS = 12,
    parameter int C_DROP_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                r0_write_en,
    input  logic [31:0]         r0_address,
    input  logic [31:0]         r0_write_data,
    output logic                r0_ready,
    input  logic                r1_write_en,
    input  logic [31:0]         r1_address,
    input  logic [31:0]         r1_write_data,
    output logic                r1_ready,
    output logic [31:0]         req_read_data,
    output logic                ctrl_clock,
    output logic                ctrl_reset,
    output logic                write_en,
    output logic [31:0]         address,
    output logic [31:0]         write_data,
    input  logic [31:0]         read_data,
    input  logic                ready,
    output logic [C_DROP_W-1:0] drop_count
);

    typedef enum logic {IDLE, WAIT} state_t;

    // Unsigned 32-bit limit for the address range check.
    localparam logic [31:0] PIX_LIM = 32'(C_PIXELS);

    state_t                state_q, state_d;
    logic [1:0]            buf_vld_q, buf_vld_d;
    logic [1:0][31:0]      buf_addr_q, buf_addr_d;
    logic [1:0][31:0]      buf_data_q, buf_data_d;
    logic                  last_grant_q, last_grant_d;
    logic                  write_en_q, write_en_d;
    logic [31:0]           address_q, address_d;
    logic [31:0]           write_data_q, write_data_d;
    logic [C_DROP_W-1:0]   drop_q, drop_d;

    logic [1:0]            req_we;
    logic [1:0][31:0]      req_addr;
    logic [1:0][31:0]      req_data;
    logic [1:0]            rej_n;
    logic                  sel;
    logic [C_DROP_W+1:0]   drop_sum;

    assign req_we   = {r1_write_en, r0_write_en};
    assign req_addr = {r1_address, r0_address};
    assign req_data = {r1_write_data, r0_write_data};

    assign r0_ready      = ~buf_vld_q[0];
    assign r1_ready      = ~buf_vld_q[1];
    assign req_read_data = read_data;
    assign ctrl_clock    = clock;
    assign ctrl_reset    = reset;
    assign write_en      = write_en_q;
    assign address       = address_q;
    assign write_data    = write_data_q;
    assign drop_count    = drop_q;

    // Next-state: buffer loads/rejects, arbitration and issue, drop counting.
    always_comb begin
        state_d      = state_q;
        buf_vld_d    = buf_vld_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        address_d    = address_q;
        write_data_d = write_data_q;
        rej_n        = 2'd0;
        sel          = 1'b0;

        // A strobe is only considered while its buffer is empty; an empty
        // buffer can never be the one being issued, so load and clear of
        // the same buffer cannot collide.
        for (int i = 0; i < 2; i++) begin
            if (req_we[i] && !buf_vld_q[i]) begin
                if (req_addr[i] < PIX_LIM) begin
                    buf_vld_d[i]  = 1'b1;
                    buf_addr_d[i] = req_addr[i];
                    buf_data_d[i] = req_data[i];
                end else begin
                    rej_n = rej_n + 2'd1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (ready && (buf_vld_q != 2'b00)) begin
                    sel            = (buf_vld_q == 2'b11) ? ~last_grant_q : buf_vld_q[1];
                    buf_vld_d[sel] = 1'b0;
                    write_en_d     = 1'b1;
                    address_d      = buf_addr_q[sel];
                    write_data_d   = buf_data_q[sel];
                    last_grant_d   = sel;
                    state_d        = WAIT;
                end
            end
            default: begin
                if (ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        drop_sum = {2'b00, drop_q} + (C_DROP_W+2)'(rej_n);
        if (drop_sum[C_DROP_W+1:C_DROP_W] != 2'b00) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[C_DROP_W-1:0];
        end
    end

    // State register; reset discards pending buffered writes and makes
    // requester 0 the winner of the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_vld_q    <= 2'b00;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            last_grant_q <= 1'b1;
            write_en_q   <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            buf_vld_q    <= buf_vld_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            drop_q       <= drop_d;
        end
    end

endmodule
